dbus_responder: RTL and testbench

- Data-bus responder (memory side) for the pipeline's load/store port; the other end of the dbus request/response handshake that the MEM stage drives.
- Holds a word-addressed 64-bit data store and answers one outstanding request at a time after a programmable latency.
- Used as the data memory in core-level simulation and as the reference target for MEM-stage load/store bring-up.

---
 rtl/dbus_responder.sv | 121 ++++++++++++
 tb/tb_dbus_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// Memory-side responder for the dbus load/store handshake: a word-addressed
// 64-bit store answering one request at a time after LATENCY wait cycles.
module dbus_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [7:0]     strb_q, strb_d;
  logic [63:0]    wdata_q, wdata_d;
  logic           ok_q;
  logic [63:0]    rdata_q;
  logic [63:0]    mem_q [DEPTH];

  // Size code and out-of-range address bits do not affect behaviour.
  logic unused_s;
  assign unused_s = ^{req_size, req_addr[63:AW+3], req_addr[2:0]};

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  strb);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Next-state logic: latch in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[3 +: AW];
          strb_d  = req_strobe;
          wdata_d = req_data;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers and the registered response, launched from RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      strb_q  <= 8'h00;
      wdata_q <= 64'h0;
      ok_q    <= 1'b0;
      rdata_q <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      ok_q    <= (state_q == RESP);
      if (state_q == RESP) begin
        rdata_q <= (strb_q == 8'h00) ? mem_q[idx_q] : 64'h0;
      end
    end
  end

  // Store is not reset; a write only commits on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (state_q == RESP && strb_q != 8'h00) begin
      mem_q[idx_q] <= merge_bytes(mem_q[idx_q], wdata_q, strb_q);
    end
  end

  assign resp_addr_ok = ok_q;
  assign resp_data_ok = ok_q;
  assign resp_data    = rdata_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized check of dbus_responder against a word/byte-lane store model,
// using three instances with LATENCY 2, 0 and 3.
module tb_dbus_responder;

  localparam int NDUT = 3;
  localparam logic [NDUT-1:0][3:0] LATS = {4'd3, 4'd0, 4'd2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NDUT-1:0]       rv, aok, dok;
  logic [NDUT-1:0][63:0] addr, wdata, rdata;
  logic [NDUT-1:0][7:0]  strb;
  logic [NDUT-1:0][2:0]  size;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] model [int];

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      dbus_responder #(.DEPTH(1024), .LATENCY(int'(LATS[g]))) u_dut (
        .clk(clk), .reset(reset), .req_valid(rv[g]), .req_addr(addr[g]),
        .req_size(size[g]), .req_strobe(strb[g]), .req_data(wdata[g]),
        .resp_addr_ok(aok[g]), .resp_data_ok(dok[g]), .resp_data(rdata[g]));
    end
  endgenerate

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int key(input int d, input logic [63:0] a);
    return d * 1024 + int'(a[12:3]);
  endfunction

  function automatic logic [63:0] rand_addr(input int idx);
    logic [63:0] a;
    logic [31:0] iv;
    a  = {$urandom, $urandom};
    iv = idx;
    a[12:3] = iv[9:0];
    return a;
  endfunction

  // Apply an operation to the model and return the response it must produce.
  function automatic logic [63:0] model_op(input int d, input logic [63:0] a,
                                           input logic [7:0] s, input logic [63:0] wd);
    logic [63:0] old_w;
    old_w = model.exists(key(d, a)) ? model[key(d, a)] : 64'h0;
    if (s != 8'h00) begin
      model[key(d, a)] = merge(old_w, wd, s);
      return 64'h0;
    end
    return old_w;
  endfunction

  task automatic txn(input int d, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] wd, output logic [63:0] got);
    int cyc;
    logic [63:0] exp;
    exp = model_op(d, a, s, wd);
    @(posedge clk); #1;
    rv[d] = 1'b1; addr[d] = a; strb[d] = s; wdata[d] = wd; size[d] = 3'd3;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (dok[d] !== 1'b1 && cyc < 40);
    chk("latency", 64'(cyc), 64'(LATS[d]) + 64'd3);
    chk("addr_ok", {63'd0, aok[d]}, 64'd1);
    chk("rdata", rdata[d], exp);
    got = rdata[d];
    rv[d] = 1'b0;
    @(negedge clk);
    chk("pulse_width", {62'd0, dok[d], aok[d]}, 64'd0);
  endtask

  initial begin
    logic [63:0] got, exp_cur, exp_a, exp_b;
    int last, n_resp, cyc;

    rv = '0; addr = '0; strb = '0; wdata = '0; size = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_ok", {62'd0, dok[d], aok[d]}, 64'd0);
      chk("reset_data", rdata[d], 64'd0);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ok", 64'({dok, aok}), 64'd0);
    end

    // Directed sequence on the LATENCY=2 instance.
    txn(0, 64'h10, 8'hFF, 64'h1122334455667788, got);
    chk("wr_resp_zero", got, 64'h0);
    txn(0, 64'h10, 8'h00, 64'h0, got);
    chk("rd_full", got, 64'h1122334455667788);
    txn(0, 64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, got);
    txn(0, 64'h10, 8'h00, 64'h0, got);
    chk("rd_partial", got, 64'h11223344BBBBBBBB);
    txn(0, 64'h13, 8'h00, 64'h0, got);
    chk("rd_lowbits", got, 64'h11223344BBBBBBBB);
    txn(0, 64'h2010, 8'hFF, 64'hDEAD, got);
    txn(0, 64'h10, 8'h00, 64'h0, got);
    chk("rd_wrap", got, 64'hDEAD);

    // Random reads/writes with wrapped addresses.
    for (int i = 0; i < 8; i++) txn(0, rand_addr(i), 8'hFF, {$urandom, $urandom}, got);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] s;
      s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      txn(0, rand_addr($urandom_range(0, 7)), s, {$urandom, $urandom}, got);
    end

    // Back-to-back stream on the LATENCY=0 instance, request held high.
    for (int i = 0; i < 8; i++) txn(1, rand_addr(i), 8'hFF, {$urandom, $urandom}, got);
    @(posedge clk); #1;
    rv[1] = 1'b1; addr[1] = rand_addr($urandom_range(0, 7)); strb[1] = 8'h00; wdata[1] = 64'h0;
    exp_cur = model_op(1, addr[1], strb[1], wdata[1]);
    last = -1; n_resp = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (dok[1] === 1'b1) begin
        n_resp++;
        if (last >= 0) chk("b2b_gap", 64'(c - last), 64'd2);
        else chk("b2b_first", 64'(c), 64'd3);
        last = c;
        chk("b2b_data", rdata[1], exp_cur);
        addr[1]  = rand_addr($urandom_range(0, 7));
        strb[1]  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        wdata[1] = {$urandom, $urandom};
        exp_cur  = model_op(1, addr[1], strb[1], wdata[1]);
      end
    end
    rv[1] = 1'b0;
    chk("b2b_count", 64'(n_resp), 64'd19);
    repeat (4) @(negedge clk);

    // Request changed and dropped during WAIT on the LATENCY=3 instance.
    txn(2, rand_addr(1), 8'hFF, {$urandom, $urandom}, got);
    txn(2, rand_addr(2), 8'hFF, {$urandom, $urandom}, got);
    exp_a = model[key(2, rand_addr(1))];
    exp_b = model[key(2, rand_addr(2))];
    @(posedge clk); #1;
    rv[2] = 1'b1; addr[2] = rand_addr(1); strb[2] = 8'h00; wdata[2] = 64'h0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        rv[2] = 1'b0; addr[2] = rand_addr(2); strb[2] = 8'hFF; wdata[2] = {$urandom, $urandom};
      end
    end while (dok[2] !== 1'b1 && cyc < 40);
    chk("chg_latency", 64'(cyc), 64'd6);
    chk("chg_data", rdata[2], exp_a);
    @(negedge clk);
    txn(2, rand_addr(2), 8'h00, 64'h0, got);
    chk("chg_no_write", got, exp_b);

    // Reset during WAIT of a write discards it.
    txn(0, 64'h20, 8'hFF, 64'h5, got);
    @(posedge clk); #1;
    rv[0] = 1'b1; addr[0] = 64'h20; strb[0] = 8'hFF; wdata[0] = 64'h99;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_ok", 64'({dok, aok}), 64'd0);
      chk("rst_mid_data", rdata[0], 64'd0);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_resp", 64'({dok, aok}), 64'd0);
    end
    txn(0, 64'h20, 8'h00, 64'h0, got);
    chk("rst_keep", got, 64'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
